// File: rtl/adc122s_pkg.sv
// adc122s_pkg: shared constants for the ADC122S conversion sequencer.
// Control-word layout, frame/result widths and frame FSM encoding.
package adc122s_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RES_W      = 12;
    localparam int ADD_LSB    = 11;
    localparam int ADD_MSB    = 13;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // {2'b00, ADD[2:0], 11'b0} with ADD = {2'b00, addr}
    function automatic logic [FRAME_BITS-1:0] ctrl_word(
        input logic addr
    );
        logic [FRAME_BITS-1:0] w;
        w = '0;
        w[ADD_MSB:ADD_LSB] = {2'b00, addr};
        return w;
    endfunction

endpackage

// File: rtl/adc122s_spi_frame.sv
// adc122s_spi_frame: one 16-SCLK chip-select frame (SETUP/SHIFT/HOLD).
// Ports: aclk, reset, start, tx_word in; sclk/ss/mosi to the ADC,
// miso from it; done (last SHIFT cycle), fin (last HOLD cycle), rx_word.
module adc122s_spi_frame
    import adc122s_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_word,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  ss,
    output logic                  mosi,
    output logic                  done,
    output logic                  fin,
    output logic [FRAME_BITS-1:0] rx_word
);

    localparam int CW = $clog2(CLK_DIV);

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [4:0]            hp;
    logic [FRAME_BITS-1:0] txsr;
    logic [FRAME_BITS-1:0] rxsr;
    logic                  cnt_end;
    logic                  go;

    assign cnt_end = (cnt == CW'(CLK_DIV - 1));
    assign done    = (state == ST_SHIFT) && cnt_end
                   && (hp == 5'd31);
    assign fin     = (state == ST_HOLD) && cnt_end;
    // A new frame may start straight out of HOLD so
    // back-to-back frames keep a 34*CLK_DIV pitch.
    assign go      = start && ((state == ST_IDLE) || fin);
    assign rx_word = rxsr;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hp    <= '0;
            txsr  <= '0;
            rxsr  <= '0;
            ss    <= 1'b1;
            sclk  <= 1'b1;
            mosi  <= 1'b0;
        end else if (go) begin
            state <= ST_SETUP;
            cnt   <= '0;
            txsr  <= tx_word;
            ss    <= 1'b0;
            mosi  <= tx_word[FRAME_BITS-1];
        end else begin
            unique case (1'b1)
                (state == ST_SETUP): begin
                    if (cnt_end) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                        hp    <= '0;
                        sclk  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                (state == ST_SHIFT): begin
                    if (!cnt_end) begin
                        cnt <= cnt + 1'b1;
                    end else if (hp == 5'd31) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                        ss    <= 1'b1;
                        mosi  <= 1'b0;
                    end else begin
                        cnt  <= '0;
                        hp   <= hp + 5'd1;
                        sclk <= ~sclk;
                        // rising edge samples, falling edge advances
                        if (!sclk) begin
                            rxsr <= {rxsr[FRAME_BITS-2:0], miso};
                        end else begin
                            txsr <= {txsr[FRAME_BITS-2:0], 1'b0};
                            mosi <= txsr[FRAME_BITS-2];
                        end
                    end
                end
                (state == ST_HOLD): begin
                    if (cnt_end) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    ss   <= 1'b1;
                    sclk <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/adc122s_sequencer.sv
// adc122s_sequencer: sample timer, round scheduler, channel tagging and
// AXIS output for a dual-channel ADC122S. Ports: aclk/reset, enable,
// ch_mask; spi_sclk/ss/mosi/miso; m_axis_tdata/tuser/tvalid/tready;
// busy (round in progress), overrun (sticky, cleared by enable=0).
module adc122s_sequencer
    import adc122s_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  ch_mask,
    output logic        spi_sclk,
    output logic        spi_ss,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic        overrun
);

    localparam int TW = $clog2(SAMPLE_PERIOD);

    logic [TW-1:0]         timer;
    logic                  tick;
    logic [1:0]            mask_q;
    logic                  cur;
    logic                  sent;
    logic                  last_addr;
    logic                  start_round;
    logic                  more;
    logic                  cont;
    logic                  next_addr;
    logic                  f_start;
    logic                  f_done;
    logic                  f_fin;
    logic [FRAME_BITS-1:0] tx_word;
    logic [FRAME_BITS-1:0] rx_word;
    logic                  unused_lead;
    logic                  take;

    assign tick = enable
               && (timer == TW'(SAMPLE_PERIOD - 1));

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (!enable || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign start_round = tick && !busy
                      && (ch_mask != 2'b00);
    assign more        = !cur && mask_q[1];
    assign cont        = busy && f_fin && more && enable;
    assign f_start     = start_round || cont;
    // Address = channel of the next frame; in the last
    // frame it wraps to the round's first enabled channel.
    // For the first frame that reduces to ch_mask[1].
    assign next_addr   = start_round ? ch_mask[1]
                                     : ~mask_q[0];
    assign tx_word     = ctrl_word(next_addr);
    assign take        = f_done
                      && (!m_axis_tvalid || m_axis_tready);
    assign unused_lead = ^rx_word[FRAME_BITS-1:RES_W];

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            busy          <= 1'b0;
            mask_q        <= 2'b00;
            cur           <= 1'b0;
            sent          <= 1'b0;
            last_addr     <= 1'b0;
            overrun       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (f_start) begin
                busy <= 1'b1;
                cur  <= start_round ? ~ch_mask[0] : 1'b1;
                sent <= next_addr;
            end else if (f_fin) begin
                busy <= 1'b0;
            end
            if (start_round) begin
                mask_q <= ch_mask;
            end
            // The ADC converted the channel addressed in
            // the previous frame, i.e. last_addr.
            if (f_done) begin
                last_addr <= sent;
            end
            if (take) begin
                m_axis_tdata  <= {{(16-RES_W){1'b0}},
                                  rx_word[RES_W-1:0]};
                m_axis_tuser  <= last_addr;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (!enable) begin
                overrun <= 1'b0;
            end else if ((tick && busy) || (f_done && !take)) begin
                overrun <= 1'b1;
            end
        end
    end

    adc122s_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .aclk    (aclk),
        .reset   (reset),
        .start   (f_start),
        .tx_word (tx_word),
        .miso    (spi_miso),
        .sclk    (spi_sclk),
        .ss      (spi_ss),
        .mosi    (spi_mosi),
        .done    (f_done),
        .fin     (f_fin),
        .rx_word (rx_word)
    );

endmodule

// File: doc/adc122s_sequencer.md
Name: adc122s_sequencer

Overview:
Conversion scheduler and SPI frame engine for the dual-channel ADC122Sxxx. A sample-rate timer starts a conversion round on every tick. Each round runs one 16-SCLK chip-select frame per channel enabled in ch_mask. Each frame sends the channel address for the next conversion and tags the returned 12-bit result with the channel it actually belongs to. Results leave on a single AXI-Stream master with the channel ID in tuser, feeding the filter/capture chain downstream.

Parameters:
CLK_DIV, 4, aclk cycles per SCLK half-period (>=2)
SAMPLE_PERIOD, 1000, aclk cycles between round starts (>= 68*CLK_DIV)

Ports:
aclk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run timer and rounds
ch_mask  in  2  bit0 = IN1 (addr 0), bit1 = IN2 (addr 1); sampled at round start
spi_sclk  out  1  SPI clock, idle high
spi_ss  out  1  chip select, active low
spi_mosi  out  1  control word, MSB first
spi_miso  in  1  ADC data
m_axis_tdata  out  16  zero-extended 12-bit result
m_axis_tuser  out  1  channel address of result
m_axis_tvalid  out  1  result valid
m_axis_tready  in  1  downstream ready
busy  out  1  round in progress
overrun  out  1  sticky error flag; cleared by reset or by enable=0

Behaviour:
- Reset values (asynchronous): spi_ss=1, spi_sclk=1, spi_mosi=0, tdata=0, tuser=0, tvalid=0, busy=0, overrun=0, timer=0, last_addr=0, FSM=IDLE.
- Timer: counts 0..SAMPLE_PERIOD-1 while enable=1, wraps, and pulses tick at wrap. Held at 0 while enable=0. First tick arrives SAMPLE_PERIOD cycles after enable rises.
- Tick with ch_mask=0: ignored.
- Tick while busy: round skipped, overrun set.
- Round order: ch0 frame first if enabled, then ch1. Frame count per round = popcount(ch_mask).
- Address sent in a frame = channel of the next frame in the round. In the round's last frame, it is the first enabled channel of the latched mask.
- Control word = {2'b00, ADD[2:0], 11'b0} with ADD = 3'b00x. Address 1 gives 16'h0800; address 0 gives 16'h0000.
- Result of a frame: tagged with last_addr as it stood at frame start. last_addr updates to the sent address at frame end. Mask changes between rounds still tag results correctly.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> (SETUP if frames remain, else IDLE).
  - IDLE: waits for a valid tick.
  - SETUP: spi_ss=0, mosi=bit15, lasts CLK_DIV cycles.
  - SHIFT: 32 half-periods of CLK_DIV cycles each. On each falling SCLK transition (after the first), mosi advances one bit. On each rising transition, miso is shifted into a 16-bit register (16 captures).
  - HOLD: spi_ss=1 for CLK_DIV cycles.
- Frame timing: ss falls at t0, rises at t0+33*CLK_DIV. Next frame's ss falls at t0+34*CLK_DIV.
- busy=1 from the first SETUP through the last HOLD.
- Output: on the edge where ss rises, tdata={4'b0, shreg[11:0]} and tuser=tag.
  - If tvalid=0 or tready=1, tvalid<=1.
  - If tvalid=1 and tready=0, the new result is dropped, the held beat is unchanged, and overrun is set.
  - tvalid clears on a tvalid&tready handshake when no new result arrives on the same edge. A handshake coinciding with a new result loads the new result and tvalid stays 1.
- enable falls mid-round: the current frame completes through HOLD, its result is emitted, remaining frames are abandoned, and the FSM goes to IDLE. overrun clears while enable=0. A pending tvalid beat is kept until accepted.
- Reset mid-frame: ss and sclk return high immediately, and the partial result is discarded.

Decomposition:
- Package adc122s_pkg: control-word ADD bit positions (13:11), frame length (16), result width (12), and the FSM state encoding.
- One sub-module, adc122s_spi_frame: runs SETUP/SHIFT/HOLD given a start pulse and a 16-bit tx word. Returns done and the 16-bit rx word.
- The top level holds the timer, round scheduler, channel tagging, and AXIS output register.

Test Plan:
- Test 1: reset, then enable=1, ch_mask=01; ADC model returns 0x0ABC.
  - Expected: first ss fall at cycle 1000, frame length 132 ss-low cycles, mosi word 0x0000, beat tdata=0x0ABC, tuser=0.
- Test 2: ch_mask=11; model returns 0x0123 for addr 0 and 0x0456 for addr 1.
  - Expected: per round, frame words 0x0800 then 0x0000; beats (0x0123,0) then (0x0456,1); repeats every 1000 cycles.
- Test 3: ch_mask 11 -> 10 between rounds.
  - Expected: next round is a single frame with word 0x0800, returning addr-0 data tagged tuser=0; the round after returns tuser=1.
- Test 4: tready=0 throughout a 2-channel round.
  - Expected: first beat held stable, second dropped, overrun=1. Then tready=1: one handshake, tvalid=0, overrun stays 1 until enable=0.
- Test 5: SAMPLE_PERIOD=200, CLK_DIV=4, ch_mask=11 (round 272 cycles).
  - Expected: every second tick skipped and overrun=1.
- Test 6: assert reset at cycle 50 of a frame, and separately drop enable at the same point.
  - Reset case: ss=1 and sclk=1 in the same cycle, no beat emitted.
  - Enable case: frame completes, one beat is emitted, then IDLE with busy=0.
